// File: rtl/swap_regfile_p.sv
// Register file with atomic two-entry swap through a temp register.
// Busy/done handshake, command rejection pulse and saturating swap count.
module swap_regfile_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              swap_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              swap_busy,
  output logic              swap_done,
  output logic              cmd_rej,
  output logic [CNT_W-1:0]  swap_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MOVE  = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] tmp_q;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;

  logic idle;
  logic accept;
  logic port_rd;
  logic port_wr;
  logic rej;

  assign idle    = (state_q == IDLE);
  assign accept  = idle && swap_req;
  assign port_rd = idle && !swap_req && re;
  assign port_wr = idle && !swap_req && we;
  assign rej     = idle ? (swap_req && (we || re))
                        : (we || re || swap_req);

  assign swap_busy = !idle;

  // State register; reset abandons any swap in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fixed three-step sequence once a swap is taken.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = swap_req ? LOAD : IDLE;
      LOAD:    state_d = MOVE;
      MOVE:    state_d = STORE;
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, temp capture, handshake pulses and swap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      tmp_q     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      swap_done <= 1'b0;
      cmd_rej   <= 1'b0;
      swap_cnt  <= '0;
    end else begin
      if (accept) begin
        a_q <= a_addr;
        b_q <= b_addr;
      end
      if (state_q == LOAD) tmp_q <= mem[a_q];
      if (port_rd) r_data <= mem[r_addr];
      r_valid   <= port_rd;
      swap_done <= (state_q == STORE);
      cmd_rej   <= rej;
      if (state_q == STORE && swap_cnt != '1)
        swap_cnt <= swap_cnt + CNT_W'(1);
    end
  end

  // Array writes: port write when idle, otherwise the swap moves.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (port_wr)                 mem[w_addr] <= w_data;
      else if (state_q == MOVE)    mem[a_q]    <= mem[b_q];
      else if (state_q == STORE)   mem[b_q]    <= tmp_q;
    end
  end

endmodule

// File: tb/tb_swap_regfile_p.sv
// Directed bench for swap_regfile_p.
// Second instance uses a 2-bit counter to exercise saturation.
module tb_swap_regfile_p;

  logic       clk;
  logic       reset;
  logic       we;
  logic [7:0] w_addr;
  logic [7:0] w_data;
  logic       re;
  logic [7:0] r_addr;
  logic       swap_req;
  logic [7:0] a_addr;
  logic [7:0] b_addr;
  logic [7:0] r_data;
  logic       r_valid;
  logic       swap_busy;
  logic       swap_done;
  logic       cmd_rej;
  logic [15:0] swap_cnt;
  logic [7:0] r_data2;
  logic       r_valid2;
  logic       swap_busy2;
  logic       swap_done2;
  logic       cmd_rej2;
  logic [1:0] swap_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  swap_regfile_p #(.DATA_W(8), .ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .re(re), .r_addr(r_addr),
    .swap_req(swap_req), .a_addr(a_addr), .b_addr(b_addr),
    .r_data(r_data), .r_valid(r_valid),
    .swap_busy(swap_busy), .swap_done(swap_done),
    .cmd_rej(cmd_rej), .swap_cnt(swap_cnt)
  );

  swap_regfile_p #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .re(re), .r_addr(r_addr),
    .swap_req(swap_req), .a_addr(a_addr), .b_addr(b_addr),
    .r_data(r_data2), .r_valid(r_valid2),
    .swap_busy(swap_busy2), .swap_done(swap_done2),
    .cmd_rej(cmd_rej2), .swap_cnt(swap_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    we = 0; re = 0; swap_req = 0;
    w_addr = 0; w_data = 0; r_addr = 0;
    a_addr = 0; b_addr = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1; w_addr = a; w_data = d;
    tick();
    we = 0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [7:0] exp);
    re = 1; r_addr = a;
    tick();
    re = 0;
    chk({tag, "_v"}, r_valid, 1);
    chk(tag, r_data, exp);
  endtask

  task automatic swap(input string tag, input logic [7:0] a,
                      input logic [7:0] b);
    swap_req = 1; a_addr = a; b_addr = b;
    tick();
    swap_req = 0; a_addr = 8'hEE; b_addr = 8'hEE;
    chk({tag, "_busy1"}, {swap_busy, swap_done}, 2'b10);
    tick();
    chk({tag, "_busy2"}, {swap_busy, swap_done}, 2'b10);
    tick();
    chk({tag, "_busy3"}, {swap_busy, swap_done}, 2'b10);
    tick();
    chk({tag, "_done"}, {swap_busy, swap_done}, 2'b01);
    tick();
    chk({tag, "_done_off"}, {swap_busy, swap_done}, 2'b00);
  endtask

  initial begin
    clr();
    reset = 1;
    tick();
    tick();
    chk("rst_rdata", r_data, 0);
    chk("rst_flags", {r_valid, swap_busy, swap_done, cmd_rej}, 0);
    chk("rst_cnt", swap_cnt, 0);
    chk("rst_cnt2", swap_cnt2, 0);
    reset = 0;
    tick();

    wr(8'd3, 8'hAA);
    wr(8'd9, 8'h55);
    swap("sw39", 8'd3, 8'd9);
    rd("rd3_a", 8'd3, 8'h55);
    rd("rd9_a", 8'd9, 8'hAA);
    chk("cnt_1", swap_cnt, 1);
    chk("cnt2_1", swap_cnt2, 1);

    wr(8'd7, 8'h3C);
    swap("sw77", 8'd7, 8'd7);
    rd("rd7", 8'd7, 8'h3C);
    chk("cnt_2", swap_cnt, 2);
    chk("cnt2_2", swap_cnt2, 2);

    swap_req = 1; a_addr = 8'd3; b_addr = 8'd9;
    tick();
    swap_req = 0;
    chk("busy_e0_rej", cmd_rej, 0);
    we = 1; w_addr = 8'd3; w_data = 8'hFF;
    re = 1; r_addr = 8'd3;
    tick();
    chk("busy_rej1", {cmd_rej, r_valid}, 2'b10);
    tick();
    chk("busy_rej2", {cmd_rej, r_valid}, 2'b10);
    tick();
    chk("busy_rej3", {cmd_rej, r_valid, swap_done}, 3'b101);
    clr();
    tick();
    chk("busy_rej_off", cmd_rej, 0);
    rd("rd3_b", 8'd3, 8'hAA);
    rd("rd9_b", 8'd9, 8'h55);
    chk("cnt_3", swap_cnt, 3);
    chk("cnt2_3", swap_cnt2, 3);

    wr(8'h10, 8'h11);
    we = 1; w_addr = 8'h10; w_data = 8'h22;
    re = 1; r_addr = 8'h10;
    tick();
    clr();
    chk("rbw_v", r_valid, 1);
    chk("rbw_old", r_data, 8'h11);
    tick();
    chk("rdata_hold", {r_valid, r_data}, {1'b0, 8'h11});
    rd("rbw_new", 8'h10, 8'h22);

    wr(8'h20, 8'h01);
    wr(8'h21, 8'h02);
    swap_req = 1; a_addr = 8'h20; b_addr = 8'h21;
    we = 1; w_addr = 8'h20; w_data = 8'hEE;
    tick();
    clr();
    chk("swwe_rej", {cmd_rej, swap_busy}, 2'b11);
    tick();
    chk("swwe_rej_off", cmd_rej, 0);
    tick();
    tick();
    chk("swwe_done", {swap_busy, swap_done}, 2'b01);
    tick();
    rd("rd20", 8'h20, 8'h02);
    rd("rd21", 8'h21, 8'h01);
    chk("cnt_4", swap_cnt, 4);
    chk("cnt2_4", swap_cnt2, 3);

    swap("sw5", 8'h20, 8'h21);
    rd("rd20_b", 8'h20, 8'h01);
    chk("cnt_5", swap_cnt, 5);
    chk("cnt2_5", swap_cnt2, 3);

    wr(8'h30, 8'hA1);
    wr(8'h31, 8'hB2);
    rd("rd30_pre", 8'h30, 8'hA1);
    swap_req = 1; a_addr = 8'h30; b_addr = 8'h31;
    tick();
    clr();
    tick();
    #2 reset = 1;
    #1;
    chk("mid_rst_busy", {swap_busy, swap_done, cmd_rej, r_valid}, 0);
    chk("mid_rst_rdata", r_data, 0);
    chk("mid_rst_cnt", swap_cnt, 0);
    chk("mid_rst_cnt2", swap_cnt2, 0);
    tick();
    reset = 0;
    tick();
    chk("post_rst_done", {swap_busy, swap_done}, 0);
    tick();
    chk("post_rst_done2", swap_done, 0);
    rd("rd31_kept", 8'h31, 8'hB2);
    wr(8'h40, 8'h5A);
    rd("rd40", 8'h40, 8'h5A);
    chk("cnt_final", swap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
